// File: rtl/memory_ctrl.sv
// Save/recall sequencer for the 4-digit snapshot register.
// It drives the register's hold control and selects live or stored digits for the display.
module memory_ctrl #(
  parameter int RECALL_CYCLES = 200,
  parameter int TMR_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_save,
  input  logic       btn_recall,
  input  logic       btn_clear,
  input  logic [3:0] live0_in,
  input  logic [3:0] live1_in,
  input  logic [3:0] live2_in,
  input  logic [3:0] live3_in,
  input  logic [3:0] mem0_in,
  input  logic [3:0] mem1_in,
  input  logic [3:0] mem2_in,
  input  logic [3:0] mem3_in,
  output logic       memory,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2,
  output logic [3:0] disp3,
  output logic       recall_active,
  output logic       mem_valid
);

  typedef enum logic [1:0] {
    TRACK   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2,
    RECALL  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] RELOAD = TMR_W'(RECALL_CYCLES - 1);

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic             mem_valid_nxt;
  logic             save_q, recall_q, clear_q;
  logic             save_p, recall_p, clear_p;

  assign save_p   = btn_save   & ~save_q;
  assign recall_p = btn_recall & ~recall_q;
  assign clear_p  = btn_clear  & ~clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= TRACK;
      timer     <= '0;
      mem_valid <= 1'b0;
      save_q    <= 1'b0;
      recall_q  <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      mem_valid <= mem_valid_nxt;
      save_q    <= btn_save;
      recall_q  <= btn_recall;
      clear_q   <= btn_clear;
    end
  end

  // Priority clear > save > recall; the timer only moves while in RECALL.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    mem_valid_nxt = mem_valid;
    if (clear_p) begin
      state_nxt     = TRACK;
      timer_nxt     = '0;
      mem_valid_nxt = 1'b0;
    end else begin
      case (state)
        TRACK: begin
          if (save_p) begin
            state_nxt     = HOLD;
            mem_valid_nxt = 1'b1;
          end
        end
        HOLD: begin
          if (save_p) begin
            state_nxt = CAPTURE;
          end else if (recall_p) begin
            state_nxt = RECALL;
            timer_nxt = RELOAD;
          end
        end
        CAPTURE: state_nxt = HOLD;
        RECALL: begin
          if (save_p)              state_nxt = CAPTURE;
          else if (recall_p)       state_nxt = HOLD;
          else if (timer == '0)    state_nxt = HOLD;
          else                     timer_nxt = timer - 1'b1;
        end
        default: state_nxt = TRACK;
      endcase
    end
  end

  // Decoded from the state register only, so the hold line cannot glitch.
  assign memory        = (state == HOLD) || (state == RECALL);
  assign recall_active = (state == RECALL);

  always_comb begin
    if (recall_active) begin
      disp0 = mem0_in;
      disp1 = mem1_in;
      disp2 = mem2_in;
      disp3 = mem3_in;
    end else begin
      disp0 = live0_in;
      disp1 = live1_in;
      disp2 = live2_in;
      disp3 = live3_in;
    end
  end

endmodule

// File: tb/tb_memory_ctrl.sv
// Scoreboard bench for memory_ctrl with a behavioural snapshot register attached.
// Digits are packed {d3,d2,d1,d0}, so live=1,2,3,4 is written 16'h4321.
module tb_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_save = 1'b0, btn_recall = 1'b0, btn_clear = 1'b0;
  logic [15:0] live = 16'h4321;
  logic [15:0] memreg = 16'h0000;
  logic        memory, recall_active, mem_valid;
  logic [3:0]  disp0, disp1, disp2, disp3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        m;
    logic        ra;
    logic        v;
    logic [15:0] d;
    string       name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  // External 4x4 register: loads live digits whenever memory is 0.
  always @(posedge clk) if (!memory) memreg <= live;

  memory_ctrl #(.RECALL_CYCLES(4), .TMR_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_save(btn_save), .btn_recall(btn_recall), .btn_clear(btn_clear),
    .live0_in(live[3:0]), .live1_in(live[7:4]), .live2_in(live[11:8]), .live3_in(live[15:12]),
    .mem0_in(memreg[3:0]), .mem1_in(memreg[7:4]), .mem2_in(memreg[11:8]), .mem3_in(memreg[15:12]),
    .memory(memory),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
    .recall_active(recall_active), .mem_valid(mem_valid)
  );

  task automatic check(input string nm, input string field, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", nm, field, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, "memory", {15'd0, memory}, {15'd0, e.m});
      check(e.name, "recall_active", {15'd0, recall_active}, {15'd0, e.ra});
      check(e.name, "mem_valid", {15'd0, mem_valid}, {15'd0, e.v});
      check(e.name, "disp", {disp3, disp2, disp1, disp0}, e.d);
    end
  end

  task automatic push(input logic m, input logic ra, input logic v, input logic [15:0] d, input string nm);
    exp_t e;
    e.m = m; e.ra = ra; e.v = v; e.d = d; e.name = nm;
    exp_q.push_back(e);
  endtask

  // One cycle: after the edge, apply buttons/live for the next edge and
  // queue the outputs expected for the remainder of this cycle.
  task automatic cyc(input logic s, input logic r, input logic c, input logic [15:0] lv,
                     input logic m, input logic ra, input logic v, input logic [15:0] d,
                     input string nm);
    @(posedge clk);
    #1;
    btn_save = s; btn_recall = r; btn_clear = c; live = lv;
    push(m, ra, v, d, nm);
  endtask

  initial begin
    // s r c  live      mem rec val disp
    cyc(0,0,0,16'h4321, 0,0,0,16'h4321, "reset");
    rst_n = 1'b1;
    cyc(1,0,0,16'h8765, 0,0,0,16'h8765, "track");
    cyc(1,0,0,16'h8765, 1,0,1,16'h8765, "save_to_hold");
    cyc(1,0,0,16'h8765, 1,0,1,16'h8765, "save_held_once");
    cyc(0,0,0,16'h9999, 1,0,1,16'h9999, "hold_live");
    cyc(0,1,0,16'h9999, 1,0,1,16'h9999, "hold_pre_recall");
    cyc(0,0,0,16'h9999, 1,1,1,16'h8765, "recall_c1");
    cyc(0,0,0,16'h9999, 1,1,1,16'h8765, "recall_c2");
    cyc(0,0,0,16'h9999, 1,1,1,16'h8765, "recall_c3");
    cyc(0,0,0,16'h9999, 1,1,1,16'h8765, "recall_c4");
    cyc(0,0,0,16'h9999, 1,0,1,16'h9999, "recall_expired");
    cyc(0,1,0,16'h9999, 1,0,1,16'h9999, "hold_again");
    cyc(0,0,0,16'h9999, 1,1,1,16'h8765, "recall2_c1");
    cyc(0,1,0,16'h9999, 1,1,1,16'h8765, "recall2_c2");
    cyc(0,0,0,16'h9999, 1,0,1,16'h9999, "recall_cancel");
    cyc(1,0,0,16'h0001, 1,0,1,16'h0001, "hold_pre_save");
    cyc(0,0,0,16'h0001, 0,0,1,16'h0001, "capture");
    cyc(0,0,0,16'h0001, 1,0,1,16'h0001, "capture_exit");
    cyc(0,1,0,16'h5555, 1,0,1,16'h5555, "hold_new_live");
    cyc(0,0,0,16'h5555, 1,1,1,16'h0001, "recall_new_snap");
    cyc(0,1,0,16'h5555, 1,1,1,16'h0001, "recall_new_snap2");
    cyc(0,0,0,16'h5555, 1,0,1,16'h5555, "recall_cancel2");
    cyc(1,1,0,16'h5555, 1,0,1,16'h5555, "hold_pre_both");
    cyc(0,0,0,16'h5555, 0,0,1,16'h5555, "save_beats_recall");
    cyc(0,0,0,16'h5555, 1,0,1,16'h5555, "capture_exit2");
    cyc(1,0,1,16'h5555, 1,0,1,16'h5555, "hold_pre_clear");
    cyc(0,0,0,16'h5555, 0,0,0,16'h5555, "clear_beats_save");
    cyc(1,0,0,16'h5555, 0,0,0,16'h5555, "track_pre_save");
    cyc(0,0,0,16'h1111, 1,0,1,16'h1111, "hold3");
    cyc(0,1,0,16'h1111, 1,0,1,16'h1111, "hold3_pre_recall");
    cyc(0,0,0,16'h1111, 1,1,1,16'h5555, "recall3_c1");
    cyc(0,0,0,16'h1111, 1,1,1,16'h5555, "recall3_c2");
    cyc(0,0,0,16'h1111, 1,1,1,16'h5555, "recall3_c3");
    cyc(1,0,0,16'h1111, 1,1,1,16'h5555, "recall3_c4");
    cyc(0,0,0,16'h1111, 0,0,1,16'h1111, "expiry_and_save");
    cyc(0,1,0,16'h1111, 1,0,1,16'h1111, "capture_exit3");
    cyc(0,0,0,16'h1111, 1,1,1,16'h1111, "recall4_c1");
    cyc(0,0,0,16'h1111, 1,1,1,16'h1111, "recall4_c2");
    // Asynchronous reset between edges while in RECALL.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    push(0,0,0,16'h1111, "async_reset");
    cyc(0,1,0,16'h1111, 0,0,0,16'h1111, "in_reset");
    rst_n = 1'b1;
    cyc(0,0,0,16'h1111, 0,0,0,16'h1111, "recall_in_track");
    cyc(0,0,0,16'h1111, 0,0,0,16'h1111, "track_after");
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
